// File: rtl/integ_scheduler.sv
// rtl/integ_scheduler.sv - time-shares one integrator between altitude and distance channels
module integ_scheduler #(
    parameter int           N          = 64,
    parameter int           PERIOD     = 10,
    parameter logic [N-1:0] TARGET_RAW = N'(64'd188_000_000_000_000),
    parameter int           TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] noair_altitude,
    input  logic [N-1:0] current_altitude,
    input  logic [N-1:0] frac_alt,
    input  logic [N-1:0] frac_dist,
    input  logic         int_ready,
    input  logic         int_result_valid,
    input  logic [N-1:0] int_result,
    output logic         int_valid,
    output logic         int_sel,
    output logic [N-1:0] int_operand,
    output logic [N-1:0] altitude,
    output logic [N-1:0] distance,
    output logic         sample_done,
    output logic         busy,
    output logic         done,
    output logic         overrun,
    output logic         error
);

    localparam int TW = $clog2(PERIOD);
    localparam int OW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_AIR,
        S_WAIT_TICK,
        S_ISSUE_ALT,
        S_WAIT_ALT,
        S_ISSUE_DIST,
        S_WAIT_DIST,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         r_state;
    logic [TW-1:0]  r_tick_cnt;
    logic [OW-1:0]  r_to_cnt;
    logic [N-1:0]   r_dist_lat;
    logic [N-1:0]   r_int_operand;
    logic [N-1:0]   r_altitude;
    logic [N-1:0]   r_distance;
    logic           r_int_valid;
    logic           r_int_sel;
    logic           r_sample_done;
    logic           r_busy;
    logic           r_done;
    logic           r_overrun;
    logic           r_error;

    logic           w_cnt_run;
    logic           w_tick;
    logic           w_to_expired;

    // The sample clock only advances while a launch is actively sampling.
    assign w_cnt_run = (r_state == S_WAIT_TICK)  || (r_state == S_ISSUE_ALT) ||
                       (r_state == S_WAIT_ALT)   || (r_state == S_ISSUE_DIST) ||
                       (r_state == S_WAIT_DIST);
    assign w_tick       = w_cnt_run && (r_tick_cnt == TW'(PERIOD - 1));
    assign w_to_expired = (r_to_cnt == OW'(TIMEOUT - 1));

    // Sequencer: tick counter, handshake, result capture and sticky status in one place.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tick_cnt    <= '0;
            r_to_cnt      <= '0;
            r_dist_lat    <= '0;
            r_int_operand <= '0;
            r_altitude    <= '0;
            r_distance    <= '0;
            r_int_valid   <= 1'b0;
            r_int_sel     <= 1'b0;
            r_sample_done <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_sample_done <= 1'b0;

            if (w_cnt_run) begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            end

            // A tick while a sample is still in flight is dropped, only flagged.
            if (w_tick && (r_state != S_WAIT_TICK)) begin
                r_overrun <= 1'b1;
            end

            if (abort) begin
                r_state     <= S_IDLE;
                r_int_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_WAIT_AIR;
                            r_busy     <= 1'b1;
                            r_overrun  <= 1'b0;
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_altitude <= '0;
                            r_distance <= '0;
                        end
                    end
                    S_WAIT_AIR: begin
                        if (noair_altitude != '0) begin
                            r_tick_cnt <= '0;
                            r_state    <= S_WAIT_TICK;
                        end
                    end
                    S_WAIT_TICK: begin
                        if (current_altitude >= TARGET_RAW) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_tick) begin
                            r_dist_lat    <= frac_dist;
                            r_int_operand <= frac_alt;
                            r_int_sel     <= 1'b0;
                            r_int_valid   <= 1'b1;
                            r_state       <= S_ISSUE_ALT;
                        end
                    end
                    S_ISSUE_ALT: begin
                        if (int_ready) begin
                            r_int_valid <= 1'b0;
                            r_to_cnt    <= '0;
                            r_state     <= S_WAIT_ALT;
                        end
                    end
                    S_WAIT_ALT: begin
                        if (int_result_valid) begin
                            r_altitude    <= int_result;
                            r_int_operand <= r_dist_lat;
                            r_int_sel     <= 1'b1;
                            r_int_valid   <= 1'b1;
                            r_state       <= S_ISSUE_DIST;
                        end else if (w_to_expired) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERROR;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    S_ISSUE_DIST: begin
                        if (int_ready) begin
                            r_int_valid <= 1'b0;
                            r_to_cnt    <= '0;
                            r_state     <= S_WAIT_DIST;
                        end
                    end
                    S_WAIT_DIST: begin
                        if (int_result_valid) begin
                            r_distance    <= int_result;
                            r_sample_done <= 1'b1;
                            r_state       <= S_WAIT_TICK;
                        end else if (w_to_expired) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERROR;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    S_DONE:  r_state <= S_DONE;
                    S_ERROR: r_state <= S_ERROR;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign int_valid   = r_int_valid;
    assign int_sel     = r_int_sel;
    assign int_operand = r_int_operand;
    assign altitude    = r_altitude;
    assign distance    = r_distance;
    assign sample_done = r_sample_done;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overrun     = r_overrun;
    assign error       = r_error;

endmodule

// File: doc/integ_scheduler.md
Name: integ_scheduler

Overview:
- Sequences and time-shares one numerical integrator between the altitude and distance channels of the trajectory datapath.
- Each sample period it latches the altitude and distance fractions, issues them to the shared integrator with a valid/ready handshake, and captures the two results into the published altitude and distance registers.
- Gates integration on a non-zero no-air altitude and stops at the target altitude.

Parameters:
- N, 64, datapath width (fixed-point, 9 decimal fraction digits).
- PERIOD, 10, clocks between sample ticks (≥4).
- TARGET_RAW, 188_000_000_000_000, target altitude in raw units (188 km × 10^9).
- TIMEOUT, 16, max clocks waiting for an integrator result.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch request (level or pulse; sampled in IDLE only).
- abort  in  1  return to IDLE from any state.
- noair_altitude  in  N  no-air altitude; zero means not yet valid.
- current_altitude  in  N  present altitude, raw units.
- frac_alt  in  N  altitude fraction for this sample.
- frac_dist  in  N  distance fraction for this sample.
- int_ready  in  1  integrator accepts operand.
- int_result_valid  in  1  integrator result strobe.
- int_result  in  N  integrator result.
- int_valid  out  1  operand offered to integrator.
- int_sel  out  1  0 = altitude channel, 1 = distance channel.
- int_operand  out  N  operand to integrator.
- altitude  out  N  integrated altitude.
- distance  out  N  integrated distance.
- sample_done  out  1  one-cycle pulse when both channels are updated.
- busy  out  1  state not IDLE, DONE or ERROR.
- done  out  1  target reached (sticky).
- overrun  out  1  sticky: tick arrived while not in WAIT_TICK.
- error  out  1  sticky: integrator timeout.

Behaviour:
- Reset: every output is 0; state IDLE; tick counter 0; operand latches 0.
- All outputs are registered. There is no asynchronous path.
- States: IDLE, WAIT_AIR, WAIT_TICK, ISSUE_ALT, WAIT_ALT, ISSUE_DIST, WAIT_DIST, DONE, ERROR.
- Transitions:
  - IDLE: start=1 → WAIT_AIR. Clears overrun, done, error, altitude and distance.
  - WAIT_AIR: noair_altitude≠0 → WAIT_TICK. Clears the tick counter.
  - WAIT_TICK: current_altitude ≥ TARGET_RAW (unsigned) → DONE; this check has priority over tick. On tick → ISSUE_ALT, latching frac_alt and frac_dist that cycle.
  - ISSUE_ALT: int_valid=1, int_sel=0, int_operand=alt latch. int_valid is held until int_ready=1, then → WAIT_ALT with int_valid dropped next cycle.
  - WAIT_ALT: int_result_valid=1 → altitude ← int_result, → ISSUE_DIST.
  - ISSUE_DIST / WAIT_DIST: same as the altitude pair with int_sel=1. On result, distance ← int_result, sample_done=1 for one cycle, → WAIT_TICK.
  - DONE: done=1; holds altitude and distance; ignores start; leaves only via abort or reset.
  - ERROR: error=1; leaves only via abort or reset.
- Tick counter:
  - Runs in every state except IDLE, WAIT_AIR, DONE and ERROR.
  - Counts 0..PERIOD-1 and wraps. Tick is asserted when count = PERIOD-1.
  - A tick seen outside WAIT_TICK sets overrun and is dropped; it is not queued.
- Timeout:
  - A counter runs in WAIT_ALT and WAIT_DIST and resets on entry.
  - Reaching TIMEOUT without int_result_valid → ERROR.
  - A result arriving in the same cycle the count expires wins.
- Results and abort:
  - int_result_valid outside WAIT_ALT/WAIT_DIST is ignored.
  - abort has priority over every transition; the next state is IDLE and int_valid is 0 next cycle.
  - A handshake coinciding with abort is discarded.
  - altitude and distance keep their values on abort; they are cleared only on a new start.
- Latency: tick cycle t → int_valid at t+1. With a zero-wait integrator (ready=1, result at the cycle after accept), sample_done occurs at t+5.
- Reset mid-operation behaves identically to the reset state, including dropping int_valid in the same cycle edge.

Test Plan:
- Reset, then start=1 with noair_altitude=0 for 20 clocks → state stays WAIT_AIR, int_valid=0. Set noair_altitude=5 → first int_valid appears 10 clocks after the counter clears.
- Zero-wait integrator returning operand+1, frac_alt=100, frac_dist=200 → int_sel sequence 0 then 1, altitude=101, distance=201, sample_done at tick+5, repeating every 10 clocks.
- int_ready held low for 12 clocks while PERIOD=10 → int_valid held with a stable operand, overrun=1, no second sample issued until the current one completes.
- Integrator never returns a result → error=1 exactly 16 clocks after entering WAIT_ALT. Then abort → IDLE, error remains 1 until the next start.
- current_altitude=188_000_000_000_000 while in WAIT_TICK → done=1 next cycle, no further int_valid, start ignored. Repeat with 187_999_999_999_999 → sampling continues.
- abort asserted in the same cycle as int_valid&int_ready → IDLE next cycle, altitude unchanged, a late int_result_valid is ignored. Apply reset mid-WAIT_DIST → all outputs 0 next cycle.
